// File: rtl/uproc_pkg.sv
// rtl/uproc_pkg.sv - shared uProcessor widths, ALU/opcode constants and sequencer state type
package uproc_pkg;

  localparam int IW = 12;
  localparam int PW = 8;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_NOT = 3'd5;
  localparam logic [2:0] ALU_LD  = 3'd6;

  localparam logic [3:0] OP_JMP  = 4'b1000;
  localparam logic [3:0] OP_JZ   = 4'b1001;
  localparam logic [3:0] OP_JC   = 4'b1010;
  localparam logic [3:0] OP_HALT = 4'b1011;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2
  } seq_state_t;

endpackage

// File: rtl/DffPIPO_CE_SET.sv
// rtl/DffPIPO_CE_SET.sv - parallel-in/parallel-out register with clock enable and async reset value
module DffPIPO_CE_SET #(
  parameter int              SIZE    = 8,
  parameter logic [SIZE-1:0] SET_VAL = '0
) (
  input  logic            clk,
  input  logic            nReset,
  input  logic            ce,
  input  logic [SIZE-1:0] d,
  output logic [SIZE-1:0] q
);

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      q <= SET_VAL;
    end else if (ce) begin
      q <= d;
    end
  end

endmodule

// File: rtl/instr_decode.sv
// rtl/instr_decode.sv - combinational decode of the IR opcode into ALU code, enables and jump kinds
module instr_decode
  import uproc_pkg::*;
(
  input  logic [3:0] op,
  output logic [2:0] alu_code,
  output logic       a_ce_en,
  output logic       cy_ce_en,
  output logic       jmp,
  output logic       jz,
  output logic       jc,
  output logic       halt
);

  always_comb begin
    alu_code = op[2:0];
    a_ce_en  = 1'b0;
    cy_ce_en = 1'b0;
    jmp      = 1'b0;
    jz       = 1'b0;
    jc       = 1'b0;
    halt     = 1'b0;
    if (!op[3]) begin
      a_ce_en  = 1'b1;
      cy_ce_en = (op[2:0] == ALU_ADD) || (op[2:0] == ALU_SUB);
    end else begin
      // 1100-1111 fall through as NOP
      case (op)
        OP_JMP:  jmp  = 1'b1;
        OP_JZ:   jz   = 1'b1;
        OP_JC:   jc   = 1'b1;
        OP_HALT: halt = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - fetch/execute sequencer driving the ALU/accumulator datapath
module instr_sequencer
  import uproc_pkg::*;
#(
  parameter int IW = uproc_pkg::IW,
  parameter int PW = uproc_pkg::PW
) (
  input  logic          clk,
  input  logic          nReset,
  input  logic          run,
  output logic          imem_req,
  output logic [PW-1:0] pc,
  input  logic          imem_valid,
  input  logic [IW-1:0] imem_data,
  input  logic          acc_zero,
  input  logic          cy,
  output logic [2:0]    alu_code,
  output logic [PW-1:0] r_out,
  output logic          a_ce,
  output logic          cy_ce,
  output logic          halted
);

  seq_state_t    state, state_nxt;
  logic [IW-1:0] ir;
  logic [PW-1:0] pc_nxt;
  logic [PW-1:0] pc_inc;
  logic          ir_ce, pc_ce, take;
  logic          a_ce_en, cy_ce_en, jmp, jz, jc, halt;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  instr_decode u_decode (
    .op       (ir[IW-1:IW-4]),
    .alu_code (alu_code),
    .a_ce_en  (a_ce_en),
    .cy_ce_en (cy_ce_en),
    .jmp      (jmp),
    .jz       (jz),
    .jc       (jc),
    .halt     (halt)
  );

  assign pc_inc = pc + PW'(1);
  assign take   = jmp | (jz & acc_zero) | (jc & cy);

  always_comb begin
    state_nxt = state;
    ir_ce     = 1'b0;
    pc_ce     = 1'b0;
    pc_nxt    = pc_inc;
    case (state)
      S_IDLE: begin
        if (run) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (imem_valid) begin
          ir_ce     = 1'b1;
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        pc_ce     = 1'b1;
        pc_nxt    = take ? ir[PW-1:0] : pc_inc;
        state_nxt = halt ? S_IDLE : S_FETCH;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  DffPIPO_CE_SET #(.SIZE(IW)) u_ir (
    .clk    (clk),
    .nReset (nReset),
    .ce     (ir_ce),
    .d      (imem_data),
    .q      (ir)
  );

  DffPIPO_CE_SET #(.SIZE(PW)) u_pc (
    .clk    (clk),
    .nReset (nReset),
    .ce     (pc_ce),
    .d      (pc_nxt),
    .q      (pc)
  );

  // Enables are pure decodes so an async reset drops them with no clock edge
  assign imem_req = (state == S_FETCH);
  assign halted   = (state == S_IDLE);
  assign a_ce     = (state == S_EXEC) && a_ce_en;
  assign cy_ce    = (state == S_EXEC) && cy_ce_en;
  assign r_out    = ir[PW-1:0];

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Multi-cycle fetch/execute sequencer for the uProcessor, directly upstream of the ALU/accumulator datapath. Fetches 12-bit instructions from program memory over a req/valid handshake and holds them in an instruction register. Drives the ALU operation code, the R operand, and the accumulator and carry register clock enables. Resolves unconditional and flag-conditional jumps from the accumulator-zero and carry flags.

## Interface
Parameters:
- IW, 12, instruction width: op[11:8], operand[7:0].
- PW, 8, program counter width, and also data width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- nReset  in  1  asynchronous, active-low reset.
- run  in  1  level; in IDLE, starts or resumes fetching.
- imem_req  out  1  fetch request; high for the whole FETCH state.
- pc  out  PW  instruction address; stable while imem_req=1.
- imem_valid  in  1  imem_data valid; sampled only when imem_req=1.
- imem_data  in  IW  instruction word.
- acc_zero  in  1  accumulator Q == 0.
- cy  in  1  carry register Q.
- alu_code  out  3  ALU operation code; equals IR op[2:0].
- r_out  out  PW  ALU R operand; equals IR operand.
- a_ce  out  1  accumulator clock enable.
- cy_ce  out  1  carry register clock enable.
- halted  out  1  high while in IDLE.

## Operation
- States: S_IDLE, S_FETCH, S_EXEC.
- IDLE:
  - run=1 → FETCH; otherwise stay.
- FETCH:
  - imem_req=1.
  - On a cycle with imem_valid=1: IR ← imem_data, then → EXEC. A combinational (same-cycle) valid is allowed.
  - Otherwise stay; pc is held.
- EXEC: lasts exactly one cycle, then → FETCH, except HALT, which → IDLE.
- Opcodes, by op = IR[11:8]:
  - 0xxx, ALU op: alu_code=op[2:0], a_ce=1. cy_ce=1 only for ALU_ADD and ALU_SUB. pc ← pc+1.
  - 1000 JMP: pc ← operand.
  - 1001 JZ: pc ← operand if acc_zero=1, else pc+1.
  - 1010 JC: pc ← operand if cy=1, else pc+1.
  - 1011 HALT: pc ← pc+1, → IDLE.
  - 1100–1111 NOP: pc ← pc+1.
  - Control ops and NOP never assert a_ce or cy_ce.
- Enable scope: a_ce and cy_ce are high only in EXEC. They are combinational decodes of state and IR.
- Flag timing: acc_zero and cy are sampled in EXEC. They reflect the previous ALU instruction, whose write completed at the end of its EXEC.
- Arithmetic: pc is 8-bit modulo; 0xFF+1 = 0x00.
- imem_valid outside FETCH is ignored.
- run is level-sensitive. After HALT, if run is still high, the next cycle re-enters FETCH.

## Timing
- Reset (async, takes effect immediately):
  - state=IDLE, pc=0x00, IR=0.
  - imem_req=0, a_ce=0, cy_ce=0, r_out=0x00, alu_code=0, halted=1.
- Reset mid-FETCH or mid-EXEC:
  - The outstanding fetch is abandoned and enables drop immediately.
  - No accumulator or carry write occurs on the following edge.
- Instruction latency: minimum 2 cycles (1 FETCH with same-cycle valid + 1 EXEC). Each extra cycle of imem_valid delay adds one cycle.
- Accumulator/carry timing: the write lands on the rising edge that ends EXEC.
- r_out and alu_code are registered (IR). They are stable from the first EXEC cycle through the following FETCH.
- pc updates on the edge ending EXEC. It is constant throughout FETCH.

## Structure
- Shared package uproc_pkg holds:
  - ALU code constants (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOT, ALU_LD); these are the single source for the ALU and this block.
  - Opcode constants OP_JMP, OP_JZ, OP_JC, OP_HALT.
  - State enum seq_state_t.
  - IW and PW.
- One sub-module, instr_decode: combinational, IR op → {alu_code, a_ce_en, cy_ce_en, jmp, jz, jc, halt}.
- IR and pc registers reuse DffPIPO_CE_SET (SIZE=IW and SIZE=PW), with CE from the FSM.

## Test plan
- Reset: nReset=0 mid-FETCH → imem_req=0, pc=0x00, halted=1, a_ce=cy_ce=0, r_out=0x00 immediately, without waiting for a clock edge.
- Program [ALU_LD 0x04, ALU_ADD 0x0A, HALT], same-cycle valid, run pulsed:
  - a_ce is high in exactly 2 cycles.
  - cy_ce is high only on the ADD.
  - Accumulator = 14, halted=1, pc=0x03.
- imem_valid delayed 3 cycles:
  - pc and imem_req stay stable for all 4 FETCH cycles.
  - No a_ce until the instruction is captured.
  - Executed result is identical to the zero-delay run.
- Program [ALU_LD 0x00, JZ 0x20] → the next fetch is at pc=0x20.
- Program [ALU_LD 0x01, JZ 0x20] → the next fetch is at pc=0x02.
- Carry path:
  - ALU_LD 0x01, ALU_ADD 0xFF → cy=1; JC 0x40 → the next fetch is at pc=0x40.
  - A following ALU_AND 0x0F → cy_ce=0, and cy stays 1.
- Wrap: JMP 0xFF, then NOP at 0xFF → the next fetch is at pc=0x00.
